// File: rtl/uart_tx16_fifo.sv
// Buffered UART transmitter: a small byte FIFO feeding a serialiser timed from
// the 16x oversample tick (start, 5-8 data bits LSB first, optional parity, 1-2 stop).
module uart_tx16_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OS_RATE    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick_16x,
    input  logic [7:0]                  s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [1:0]                  data_bits,
    input  logic                        parity_en,
    input  logic                        parity_odd,
    input  logic                        two_stop,
    output logic                        tx_out,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TICK_W = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OS_RATE - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t            state;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        data_q;
    logic [1:0]        dbits_q;
    logic              par_en_q;
    logic              two_stop_q;
    logic              par_bit;

    logic              push;
    logic              pop;
    logic              last_stop;
    logic [7:0]        head;
    logic [7:0]        width_mask;
    logic [2:0]        last_idx;
    logic [2:0]        next_idx;

    assign s_ready    = (fifo_count != FULL_CNT);
    assign push       = s_valid && s_ready;
    assign head       = mem[rd_ptr];
    assign last_stop  = (state == STOP2) || ((state == STOP1) && !two_stop_q);
    // Pop either from idle or on the very tick that ends the last stop bit.
    assign pop        = tick_16x && (fifo_count != '0) &&
                        ((state == IDLE) || (last_stop && (tick_cnt == TICK_LAST)));
    assign width_mask = 8'hFF >> (2'd3 - data_bits);
    assign last_idx   = 3'd4 + 3'(dbits_q);
    assign next_idx   = bit_idx + 3'd1;

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers/count, frame configuration latch and serialiser FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            data_q     <= '0;
            dbits_q    <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit    <= 1'b0;
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);

            if (pop) begin
                data_q     <= head;
                dbits_q    <= data_bits;
                par_en_q   <= parity_en;
                two_stop_q <= two_stop;
                par_bit    <= (^(head & width_mask)) ^ parity_odd;
                state      <= START;
                tick_cnt   <= '0;
                tx_out     <= 1'b0;
                tx_busy    <= 1'b1;
            end else if (tick_16x && (state != IDLE)) begin
                if (tick_cnt != TICK_LAST) begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end else begin
                    tick_cnt <= '0;
                    case (state)
                        START: begin
                            state   <= DATA;
                            bit_idx <= '0;
                            tx_out  <= data_q[0];
                        end
                        DATA: begin
                            if (bit_idx == last_idx) begin
                                if (par_en_q) begin
                                    state  <= PARITY;
                                    tx_out <= par_bit;
                                end else begin
                                    state  <= STOP1;
                                    tx_out <= 1'b1;
                                end
                            end else begin
                                bit_idx <= next_idx;
                                tx_out  <= data_q[next_idx];
                            end
                        end
                        PARITY: begin
                            state  <= STOP1;
                            tx_out <= 1'b1;
                        end
                        STOP1: begin
                            tx_out <= 1'b1;
                            if (two_stop_q) begin
                                state <= STOP2;
                            end else begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                            end
                        end
                        default: begin
                            state   <= IDLE;
                            tx_out  <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx16_fifo.sv
// Directed bench for uart_tx16_fifo: tick every 4 clk, so each bit lasts 64 clk;
// outputs are sampled on the falling clock edge.
module tb_uart_tx16_fifo;
    logic       clk;
    logic       rst;
    logic       tick_16x;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
    logic       tx_out;
    logic       tx_busy;
    logic [2:0] fifo_count;

    logic       tick_en;
    logic [1:0] div;
    int         n_cmp;
    int         n_bad;

    uart_tx16_fifo #(.FIFO_DEPTH(4), .OS_RATE(16)) dut (
        .clk(clk), .rst(rst), .tick_16x(tick_16x),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd),
        .two_stop(two_stop), .tx_out(tx_out), .tx_busy(tx_busy),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clock tick pulse every fourth clock while enabled.
    initial begin
        tick_16x = 1'b0;
        div      = 2'd0;
        forever begin
            @(negedge clk);
            tick_16x = tick_en && (div == 2'd3);
            div      = div + 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic pe, input logic po, input logic ts);
        data_bits  = db;
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
    endtask

    // Checks one whole frame; aligned=1 means the current negedge is the one after the pop.
    task automatic check_frame(input logic [7:0] d, input int n, input logic pe, input logic po,
                               input logic ts, input logic aligned, input logic last,
                               input string tag);
        logic [11:0] bits;
        logic        par;
        int          len;
        int          m;
        int          w;
        bits    = '0;
        par     = po;
        bits[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            bits[1 + i] = d[i];
            par         = par ^ d[i];
        end
        len = 1 + n;
        if (pe) begin
            bits[len] = par;
            len++;
        end
        bits[len] = 1'b1;
        len++;
        if (ts) begin
            bits[len] = 1'b1;
            len++;
        end
        if (!aligned) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (tx_out !== 1'b0 && w < 2000);
            chk({tag, "_start_seen"}, 32'(tx_out), 32'd0);
        end
        m = 0;
        for (int k = 0; k < len; k++) begin
            repeat (64 * k + 32 - m) @(negedge clk);
            m = 64 * k + 32;
            chk($sformatf("%s_bit%0d", tag, k), 32'(tx_out), 32'(bits[k]));
        end
        repeat (64 * len - 1 - m) @(negedge clk);
        chk({tag, "_busy_end"}, 32'(tx_busy), 32'd1);
        @(negedge clk);
        if (last) begin
            chk({tag, "_idle_tx"}, 32'(tx_out), 32'd1);
            chk({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
        end else begin
            chk({tag, "_next_start"}, 32'(tx_out), 32'd0);
            chk({tag, "_next_busy"}, 32'(tx_busy), 32'd1);
        end
    endtask

    initial begin
        int w;
        int lows;
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        tick_en = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx_out), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        rst = 1'b0;
        tick_en = 1'b1;

        // 8N1 single byte, then idle ticks must do nothing
        push(8'h55);
        chk("8n1_count", 32'(fifo_count), 32'd1);
        check_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "8n1");
        repeat (200) @(negedge clk);
        chk("idle_tx", 32'(tx_out), 32'd1);
        chk("idle_busy", 32'(tx_busy), 32'd0);
        chk("idle_count", 32'(fifo_count), 32'd0);

        // 7O2 single byte
        set_cfg(2'd2, 1'b1, 1'b1, 1'b1);
        push(8'h41);
        check_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "7o2");

        // Fill FIFO with s_valid held, fifth byte waits for the first pop
        tick_en = 1'b0;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'hA0;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            s_data = 8'hA0 + 8'(i);
        end
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(s_ready), 32'd0);
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (s_ready) begin
                        @(negedge clk);
                        s_valid = 1'b0;
                        break;
                    end
                end
            end
        join_none
        tick_en = 1'b1;
        check_frame(8'hA0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b0");
        check_frame(8'hA1, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b1");
        check_frame(8'hA2, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b2");
        check_frame(8'hA3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b3");
        check_frame(8'hA4, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "b2b4");
        chk("b2b_count", 32'(fifo_count), 32'd0);
        s_valid = 1'b0;

        // Width change during frame 1 only affects frame 2
        tick_en = 1'b0;
        push(8'h96);
        push(8'h3B);
        tick_en = 1'b1;
        fork
            begin
                check_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "cfg1");
                check_frame(8'h3B, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "cfg2");
            end
            begin
                repeat (300) @(negedge clk);
                data_bits = 2'd0;
            end
        join

        // Reset in the middle of a frame with bytes still queued
        tick_en = 1'b0;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        push(8'h12);
        push(8'h34);
        push(8'h56);
        chk("mid_count", 32'(fifo_count), 32'd3);
        tick_en = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (tx_out !== 1'b0 && w < 2000);
        chk("mid_start_seen", 32'(tx_out), 32'd0);
        repeat (100) @(negedge clk);
        chk("mid_busy", 32'(tx_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", 32'(tx_out), 32'd1);
        chk("arst_busy", 32'(tx_busy), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst  = 1'b0;
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_out !== 1'b1) lows++;
        end
        chk("post_rst_lows", 32'(lows), 32'd0);
        chk("post_rst_busy", 32'(tx_busy), 32'd0);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        push(8'h7E);
        chk("post_rst_push", 32'(fifo_count), 32'd1);
        check_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst");

        // 8E1 back-to-back patterns
        tick_en = 1'b0;
        set_cfg(2'd3, 1'b1, 1'b0, 1'b0);
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        tick_en = 1'b1;
        check_frame(8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "8e1_00");
        check_frame(8'hFF, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "8e1_ff");
        check_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "8e1_3c");
        chk("end_count", 32'(fifo_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
